// File: rtl/dmem_pkg.sv
// Shared definitions for the banked data memory: FSM states, store byte-lane enables,
// read-latency bounds, the read-beat record and the byte-merge helper.
package dmem_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } dmem_state_e;

    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_BYTE1   = 4'b0010;
    localparam logic [3:0] BE_BYTE2   = 4'b0100;
    localparam logic [3:0] BE_BYTE3   = 4'b1000;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 4;

    typedef struct packed {
        logic        valid;
        logic        oor;
        logic [31:0] data;
    } rd_beat_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_banked_if.sv
// MEM-stage request/response bus of the data memory.
interface dmem_banked_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] now_pc;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        oor;

    modport master (
        output req, we, be, addr, wdata, now_pc,
        input  ready, rvalid, rdata, oor
    );

    modport slave (
        input  req, we, be, addr, wdata, now_pc,
        output ready, rvalid, rdata, oor
    );
endinterface

// File: rtl/dmem_rd_pipe.sv
// Read-return delay line carrying {valid, oor, data}; data only advances with a valid beat,
// so the output data holds between pulses. Asynchronous active-low flush.
module dmem_rd_pipe #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 34
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] out_o
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;
    logic [DEPTH:0][WIDTH-1:0]   chain;

    always_comb begin
        chain    = '0;
        chain[0] = in_i;
        for (int i = 0; i < DEPTH; i++) begin
            chain[i+1] = stage_q[i];
        end
        for (int i = 0; i < DEPTH; i++) begin
            stage_d[i] = {chain[i][WIDTH-1], chain[i][WIDTH-2],
                          chain[i][WIDTH-1] ? chain[i][WIDTH-3:0] : stage_q[i][WIDTH-3:0]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign out_o = stage_q[DEPTH-1];

endmodule

// File: rtl/dmem_banked.sv
// Word-organised data memory with byte enables, post-reset clear walk and configurable read
// latency. Define DMEM_TRACE_EN to print every accepted in-range store.
module dmem_banked
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned RD_LAT     = 1
) (
    input logic          clk,
    input logic          reset,
    dmem_banked_if.slave bus
);

    localparam int unsigned Words = 1 << DEPTH_LOG2;
    localparam int unsigned RdLat = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                                    (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

    dmem_state_e           state_q, state_d;
    logic [DEPTH_LOG2-1:0] clr_idx_q, clr_idx_d;
    logic                  wr_oor_q, wr_oor_d;
    logic                  clr_en;

    logic [31:0]           mem [Words];
    logic [DEPTH_LOG2-1:0] idx;
    logic                  in_range, accept, wr_en;
    logic [31:0]           rd_word, merged;
    rd_beat_t              rd_in, rd_out;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
            wr_oor_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            wr_oor_q  <= wr_oor_d;
        end
    end

    // Next state: walk every word once, leave on the edge that clears the last one
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == ST_CLEAR) begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == '1) state_d = ST_RUN;
        end
    end

    // Outputs
    always_comb begin
        bus.ready  = (state_q == ST_RUN);
        clr_en     = (state_q == ST_CLEAR);
        bus.rvalid = rd_out.valid;
        bus.rdata  = rd_out.data;
        bus.oor    = rd_out.oor | wr_oor_q;
    end

    assign idx      = bus.addr[DEPTH_LOG2+1:2];
    assign in_range = (bus.addr >> (DEPTH_LOG2 + 2)) == 32'd0;
    assign accept   = bus.ready & bus.req;
    assign wr_en    = accept & bus.we & in_range;
    assign rd_word  = mem[idx];
    assign merged   = merge_bytes(rd_word, bus.wdata, bus.be);

    always_comb begin
        wr_oor_d     = accept & bus.we & ~in_range;
        rd_in.valid  = accept & ~bus.we;
        rd_in.oor    = accept & ~bus.we & ~in_range;
        rd_in.data   = in_range ? rd_word : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[clr_idx_q] <= '0;
        end else if (wr_en) begin
            mem[idx] <= merged;
        end
    end

    dmem_rd_pipe #(
        .DEPTH (RdLat),
        .WIDTH ($bits(rd_beat_t))
    ) u_rd_pipe (
        .clk_i  (clk),
        .rst_ni (reset),
        .in_i   (rd_in),
        .out_o  (rd_out)
    );

`ifdef DMEM_TRACE_EN
    always_ff @(posedge clk) begin
        if (wr_en && (bus.be != 4'b0000)) begin
            $display("%0t@%h: *%h <= %h", $time, bus.now_pc, {bus.addr[31:2], 2'b00}, merged);
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^bus.now_pc;
`endif

endmodule
